// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode values and
// the stage-count / configuration helpers evaluated at elaboration.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    if (chunk == 0) return 0;
    return width / chunk;
  endfunction

  // WIDTH must split into a whole, non-zero number of CHUNK-bit slices.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned chunk);
    if (chunk < 1) return 1'b0;
    if (width % chunk != 0) return 1'b0;
    return (width / chunk) >= 1;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline slice: resolves chunk IDX of the sum with a registered carry and
// forwards operands, partial sum and valid bit to the next slice.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] part_sum,
  output logic             carry
);

  localparam int unsigned LO = IDX * CHUNK;

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] next_sum;

  always_comb begin
    slice = {1'b0, prev_a[LO +: CHUNK]} + {1'b0, prev_b[LO +: CHUNK]}
          + {{CHUNK{1'b0}}, prev_carry};
    next_sum = prev_sum;
    next_sum[LO +: CHUNK] = slice[CHUNK-1:0];
  end

  // Data only loads with a valid beat, so the last slice keeps the most
  // recent result visible while bubbles pass through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      a        <= '0;
      b        <= '0;
      part_sum <= '0;
      carry    <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a        <= prev_a;
        b        <= prev_b;
        part_sum <= next_sum;
        carry    <= slice[CHUNK];
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Streaming add/subtract: operands are resolved CHUNK bits per stage with a
// registered carry between stages, under a single global advance enable.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             v_pipe [STAGES+1];
  logic             c_pipe [STAGES+1];
  logic [WIDTH-1:0] a_pipe [STAGES+1];
  logic [WIDTH-1:0] b_pipe [STAGES+1];
  logic [WIDTH-1:0] s_pipe [STAGES+1];
  logic             unused_ops;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is x + ~y + ~cin, so borrow-in becomes an inverted carry-in.
  assign b_eff   = (op == OP_SUB) ? ~y : y;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;

  assign v_pipe[0] = in_valid;
  assign c_pipe[0] = cin_eff;
  assign a_pipe[0] = x;
  assign b_pipe[0] = b_eff;
  assign s_pipe[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .prev_valid (v_pipe[k]),
      .prev_a     (a_pipe[k]),
      .prev_b     (b_pipe[k]),
      .prev_sum   (s_pipe[k]),
      .prev_carry (c_pipe[k]),
      .valid      (v_pipe[k+1]),
      .a          (a_pipe[k+1]),
      .b          (b_pipe[k+1]),
      .part_sum   (s_pipe[k+1]),
      .carry      (c_pipe[k+1])
    );
  end

  assign out_valid = v_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1])
                  && (s_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);

  // Only the operand sign bits matter after the last slice.
  assign unused_ops = ^{a_pipe[STAGES], b_pipe[STAGES]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed corner cases on a 16/4 unit
// plus randomized streams on 16/4, 16/16 and 32/8 against an arithmetic model.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_done [3];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Integer arithmetic reference: unsigned result for sum/cout, signed for ovf.
  function automatic exp_t model(int w, logic op_v, logic [31:0] xv, logic [31:0] yv,
                                 logic cin_v, int due);
    longint m, ux, uy, sx, sy, u, s, c;
    exp_t e;
    m  = longint'(1) << w;
    ux = longint'(xv);
    uy = longint'(yv);
    c  = cin_v ? 1 : 0;
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (op_v == OP_ADD) begin
      u = ux + uy + c;
      s = sx + sy + c;
      e.cout = (u >= m);
    end else begin
      u = ux - uy - c;
      s = sx - sy - c;
      e.cout = (u >= 0);
    end
    u = ((u % m) + m) % m;
    e.sum = 32'(u);
    e.ovf = (s < -(m / 2)) || (s >= m / 2);
    e.due = due;
    return e;
  endfunction

  // ---------------- directed unit, 16/4 ----------------
  logic        d_rst_n, d_in_valid, d_in_ready, d_op, d_cin;
  logic        d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [15:0] d_x, d_y, d_sum;
  exp_t        dq[$];
  int          inr_low = 0;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst_n     (d_rst_n),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .op        (d_op),
    .x         (d_x),
    .y         (d_y),
    .cin       (d_cin),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .sum       (d_sum),
    .cout      (d_cout),
    .ovf       (d_ovf)
  );

  task automatic drive(input logic op_v, input logic [15:0] xv, input logic [15:0] yv,
                       input logic cin_v, input exp_t e, input bit timed);
    int waits;
    waits = 0;
    d_in_valid = 1'b1;
    d_op  = op_v;
    d_x   = xv;
    d_y   = yv;
    d_cin = cin_v;
    @(negedge clk);
    while (d_in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("in_ready_wait_bound", 64'(waits < 20), 64'd1);
    e.due = timed ? cyc + 4 : -1;
    dq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lit(input logic op_v, input logic [15:0] xv, input logic [15:0] yv,
                           input logic cin_v, input logic [15:0] esum, input logic ecout,
                           input logic eovf);
    exp_t e;
    e.sum  = 32'(esum);
    e.cout = ecout;
    e.ovf  = eovf;
    e.due  = -1;
    drive(op_v, xv, yv, cin_v, e, 1'b1);
  endtask

  task automatic drive_rand();
    logic        op_v, cin_v;
    logic [15:0] xv, yv;
    op_v  = 1'($urandom_range(1));
    cin_v = 1'($urandom_range(1));
    xv    = 16'($urandom());
    yv    = 16'($urandom());
    drive(op_v, xv, yv, cin_v, model(16, op_v, 32'(xv), 32'(yv), cin_v, -1), 1'b0);
  endtask

  always @(negedge clk) begin
    chk("d_in_ready_rule", 64'(d_in_ready), 64'(!d_out_valid || d_out_ready));
    if (d_in_ready === 1'b0) inr_low++;
    if (d_out_valid === 1'b1) begin
      if (dq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d_unexpected_beat: out_valid got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("d_sum",  64'(d_sum),  64'(dq[0].sum));
        chk("d_cout", 64'(d_cout), 64'(dq[0].cout));
        chk("d_ovf",  64'(d_ovf),  64'(dq[0].ovf));
        if (d_out_ready) begin
          if (dq[0].due >= 0) chk("d_latency", 64'(cyc), 64'(dq[0].due));
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    d_rst_n = 1'b0;
    d_in_valid = 1'b1;
    d_op = OP_ADD;
    d_x = 16'hABCD;
    d_y = 16'h1111;
    d_cin = 1'b1;
    d_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(d_out_valid), 64'd0);
    chk("rst_sum",       64'(d_sum),       64'd0);
    chk("rst_cout",      64'(d_cout),      64'd0);
    chk("rst_ovf",       64'(d_ovf),       64'd0);
    d_rst_n = 1'b1;
    d_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(d_in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    drive_lit(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive_lit(OP_ADD, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    drive_lit(OP_SUB, 16'h0005, 16'h000A, 1'b0, 16'hFFFB, 1'b0, 1'b0);
    drive_lit(OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    drive_lit(OP_SUB, 16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b1, 1'b0);
    d_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("directed_drained", 64'(dq.size()), 64'd0);

    // 2nd result of the burst becomes visible 5 edges after the first beat is offered.
    fork
      begin
        for (int i = 0; i < 8; i++) drive_rand();
        d_in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        d_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d_out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("bp_drained", 64'(dq.size()), 64'd0);
    chk("bp_stall_cycles", 64'(inr_low), 64'd3);

    for (int i = 0; i < 3; i++) drive_rand();
    d_rst_n = 1'b0;
    d_in_valid = 1'b0;
    dq.delete();
    @(posedge clk);
    #1;
    d_rst_n = 1'b1;
    drive_lit(OP_ADD, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    d_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_drained", 64'(dq.size()), 64'd0);
    chk("hold_sum", 64'(d_sum), 64'h5555);

    wait (rand_done[0] && rand_done[1] && rand_done[2]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- randomized units ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 2) ? 32 : 16;
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 16 : 8);

    logic         r_rst_n, r_in_valid, r_in_ready, r_op, r_cin;
    logic         r_out_valid, r_out_ready, r_cout, r_ovf;
    logic [W-1:0] r_x, r_y, r_sum;
    exp_t         q[$];

    pipelined_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (r_rst_n),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .op        (r_op),
      .x         (r_x),
      .y         (r_y),
      .cin       (r_cin),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .sum       (r_sum),
      .cout      (r_cout),
      .ovf       (r_ovf)
    );

    function automatic logic [W-1:0] pick();
      logic [63:0] rnd;
      rnd = {$urandom(), $urandom()};
      case ($urandom_range(7))
        0:       return '1;
        1:       return '0;
        2:       return {1'b0, {(W-1){1'b1}}};
        3:       return {1'b1, {(W-1){1'b0}}};
        default: return W'(rnd);
      endcase
    endfunction

    initial begin
      r_rst_n = 1'b0;
      r_in_valid = 1'b0;
      r_op = OP_ADD;
      r_cin = 1'b0;
      r_x = '0;
      r_y = '0;
      r_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      r_rst_n = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        r_in_valid  = ($urandom_range(3) != 0);
        r_op        = 1'($urandom_range(1));
        r_cin       = 1'($urandom_range(1));
        r_x         = pick();
        r_y         = pick();
        r_out_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        if (r_in_valid && r_in_ready)
          q.push_back(model(W, r_op, 32'(r_x), 32'(r_y), r_cin, -1));
        @(posedge clk);
        #1;
      end
      r_in_valid = 1'b0;
      r_out_ready = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
      #1;
      chk($sformatf("rand%0d_drained", g), 64'(q.size()), 64'd0);
      rand_done[g] = 1'b1;
    end

    always @(negedge clk) begin
      if (r_rst_n === 1'b1) begin
        chk($sformatf("rand%0d_in_ready_rule", g), 64'(r_in_ready),
            64'(!r_out_valid || r_out_ready));
        if (r_out_valid === 1'b1) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand%0d_unexpected_beat: out_valid got 1 expected 0 (cycle %0d)",
                     g, cyc);
          end else begin
            chk($sformatf("rand%0d_sum", g),  64'(r_sum),  64'(q[0].sum));
            chk($sformatf("rand%0d_cout", g), 64'(r_cout), 64'(q[0].cout));
            chk($sformatf("rand%0d_ovf", g),  64'(r_ovf),  64'(q[0].ovf));
            if (r_out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

endmodule
